tc_array: RTL and testbench

- Parametrised successor to the single-channel timer/counter that feeds CP0 HWInt.
- Holds N_CH independent down-counting timers behind one bridge-facing register window, at 16 bytes per channel.
- Each channel supports one-shot, auto-reload and free-running modes, a per-channel interrupt mask and a sticky pending flag.
- Per-channel IRQs are presented individually and OR-reduced, so the CPU top wires irq bits straight into HWInt.

---
 rtl/tc_array.sv | 183 ++++++++++++++++++
 tb/tb_tc_array.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_array.sv
// tc_array: N_CH independent down-counting timers behind one bus window.
// Build option TC_PRESCALE_EN turns register 3 into a 16-bit prescaler.
module tc_array #(
  parameter int          N_CH  = 2,
  parameter int          WIDTH = 32,
  parameter logic [31:0] BASE  = 32'h0000_7F00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [29:0]     addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [N_CH-1:0] irq,
  output logic            irq_any
);

  localparam int CH_BITS = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  logic [CH_BITS-1:0]     ch;
  logic [3:0]             ch_ext;
  logic [1:0]             reg_sel;
  logic                   hit;
  logic [N_CH-1:0][31:0]  rv;
  logic                   unused_wdata;

  // addr is a word address, so byte bits [3:2] are addr[1:0]
  assign reg_sel      = addr[1:0];
  assign ch           = addr[CH_BITS+1:2];
  assign ch_ext       = 4'(ch);
  assign hit          = (addr[29:CH_BITS+2] == BASE[31:CH_BITS+4])
                     && (ch_ext < 4'(N_CH));
  assign unused_wdata = ^wdata;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state;
    state_t           state_nx;
    logic             en;
    logic             im;
    logic             pend;
    logic [1:0]       mode;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nx;
    logic             pend_set;
    logic             en_clr;
    logic             tick;
    logic             sel;
    logic             ctrl_wr;
    logic             preset_wr;
    logic [31:0]      rd_val;

    assign sel       = hit && we && (ch_ext == 4'(i));
    assign ctrl_wr   = sel && (reg_sel == 2'd0);
    assign preset_wr = sel && (reg_sel == 2'd1);

`ifdef TC_PRESCALE_EN
    logic        pscl_wr;
    logic [15:0] pscl;
    logic [15:0] div;

    assign pscl_wr = sel && (reg_sel == 2'd3);
    assign tick    = (div == pscl);

    always_ff @(posedge clk) begin
      if (reset) begin
        pscl <= '0;
        div  <= '0;
      end else begin
        if (pscl_wr)
          pscl <= wdata[15:0];
        if (pscl_wr || state == S_LOAD)
          div <= '0;
        else if (state == S_CNT && en)
          div <= tick ? 16'd0 : div + 16'd1;
      end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
      state_nx = state;
      count_nx = count;
      pend_set = 1'b0;
      en_clr   = 1'b0;
      unique case (state)
        S_IDLE: begin
          if (en)
            state_nx = S_LOAD;
        end
        S_LOAD: begin
          count_nx = preset;
          state_nx = S_CNT;
        end
        S_CNT: begin
          if (!en) begin
            state_nx = S_IDLE;
          end else if (tick) begin
            if (mode == 2'b10) begin
              count_nx = count - WIDTH'(1);
              pend_set = (count == '0);
            end else if (count > WIDTH'(1)) begin
              count_nx = count - WIDTH'(1);
            end else begin
              count_nx = '0;
              pend_set = 1'b1;
              state_nx = S_INT;
            end
          end
        end
        S_INT: begin
          // auto-reload skips straight to LOAD; others park in IDLE
          en_clr   = (mode == 2'b00) || (mode == 2'b11);
          state_nx = (en && mode == 2'b01) ? S_LOAD : S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= S_IDLE;
        en     <= 1'b0;
        im     <= 1'b0;
        pend   <= 1'b0;
        mode   <= 2'b00;
        preset <= '0;
        count  <= '0;
      end else begin
        state <= state_nx;
        count <= count_nx;
        if (ctrl_wr) begin
          en   <= wdata[0];
          mode <= wdata[2:1];
          im   <= wdata[3];
        end else if (en_clr) begin
          en <= 1'b0;
        end
        if (preset_wr)
          preset <= wdata[WIDTH-1:0];
        // a software write beats a same-cycle hardware set
        if (ctrl_wr || preset_wr)
          pend <= 1'b0;
        else if (pend_set)
          pend <= 1'b1;
      end
    end

    always_comb begin
      rd_val = '0;
      case (reg_sel)
        2'd0:    rd_val = {27'd0, pend, im, mode, en};
        2'd1:    rd_val = 32'(preset);
        2'd2:    rd_val = 32'(count);
`ifdef TC_PRESCALE_EN
        2'd3:    rd_val = 32'(pscl);
`endif
        default: rd_val = '0;
      endcase
    end

    assign rv[i]  = rd_val;
    assign irq[i] = im & pend;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CH; i++)
      if (hit && ch_ext == 4'(i))
        rdata = rv[i];
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_tc_array.sv
// tb_tc_array: directed vectors for tc_array (2x32-bit and 4x8-bit builds).
// Register table first, then timed sequences for the counter FSM.
module tb_tc_array;

  localparam logic [31:0] B = 32'h0000_7F00;
`ifdef TC_PRESCALE_EN
  localparam logic [31:0] R3_EXP = 32'h0000_5678;
`else
  localparam logic [31:0] R3_EXP = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] addr = '0;
  logic [29:0] addr4 = '0;
  logic        we = 1'b0;
  logic        we4 = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] wdata4 = '0;
  logic [31:0] rdata;
  logic [31:0] rdata4;
  logic [1:0]  irq;
  logic        irq_any;
  logic [3:0]  irq4;
  logic        irq4_any;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic        d;
    logic [31:0] ba;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[18];

  tc_array dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .irq(irq), .irq_any(irq_any)
  );

  tc_array #(.N_CH(4), .WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .addr(addr4), .we(we4),
    .wdata(wdata4), .rdata(rdata4), .irq(irq4), .irq_any(irq4_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input bit d, input logic [31:0] ba,
                    input logic [31:0] v);
    if (d) begin
      addr4 = ba[31:2]; wdata4 = v; we4 = 1'b1;
    end else begin
      addr = ba[31:2]; wdata = v; we = 1'b1;
    end
    @(negedge clk);
    we = 1'b0;
    we4 = 1'b0;
  endtask

  task automatic rd(input bit d, input logic [31:0] ba,
                    output logic [31:0] v);
    if (d) addr4 = ba[31:2];
    else   addr = ba[31:2];
    #1;
    v = d ? rdata4 : rdata;
  endtask

  task automatic rdchk(input bit d, input logic [31:0] ba,
                       input logic [31:0] exp, input string nm);
    logic [31:0] v;
    rd(d, ba, v);
    chk(nm, v, exp);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    int n;
    logic [31:0] cseq[10];
    logic [31:0] iseq[10];

    vt[0]  = '{1'b0, 1'b0, B + 32'h00, 32'h0,        32'h0};
    vt[1]  = '{1'b0, 1'b0, B + 32'h14, 32'h0,        32'h0};
    vt[2]  = '{1'b0, 1'b0, B + 32'h18, 32'h0,        32'h0};
    vt[3]  = '{1'b1, 1'b0, B + 32'h14, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[4]  = '{1'b1, 1'b0, B + 32'h10, 32'hFFFFFFE6, 32'h6};
    vt[5]  = '{1'b1, 1'b0, B + 32'h08, 32'h12345678, 32'h0};
    vt[6]  = '{1'b1, 1'b0, B + 32'h0C, 32'h12345678, R3_EXP};
    vt[7]  = '{1'b1, 1'b0, B + 32'h20, 32'hFFFFFFFF, 32'h0};
    vt[8]  = '{1'b0, 1'b0, B + 32'h00, 32'h0,        32'h0};
    vt[9]  = '{1'b0, 1'b0, B + 32'h04, 32'h0,        32'h0};
    vt[10] = '{1'b1, 1'b0, B - 32'h04, 32'hFFFFFFFF, 32'h0};
    vt[11] = '{1'b0, 1'b0, B + 32'h1C, 32'h0,        32'h0};
    vt[12] = '{1'b1, 1'b1, B + 32'h34, 32'h000001FF, 32'hFF};
    vt[13] = '{1'b1, 1'b1, B + 32'h30, 32'h0000000A, 32'hA};
    vt[14] = '{1'b0, 1'b1, B + 32'h14, 32'h0,        32'h0};
    vt[15] = '{1'b0, 1'b1, B + 32'h10, 32'h0,        32'h0};
    vt[16] = '{1'b1, 1'b1, B + 32'h40, 32'hFFFFFFFF, 32'h0};
    vt[17] = '{1'b0, 1'b1, B + 32'h00, 32'h0,        32'h0};

    cseq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0,
             32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    iseq = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1,
             32'd1, 32'd1, 32'd1, 32'd1, 32'd1};

    step(2);
    reset = 1'b0;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_irq_any", 32'(irq_any), 32'h0);
    chk("rst_irq4", 32'(irq4), 32'h0);

    for (int i = 0; i < 18; i++) begin
      if (vt[i].we)
        wr(vt[i].d, vt[i].ba, vt[i].wd);
      rd(vt[i].d, vt[i].ba, v);
      checks++;
      if (v !== vt[i].exp) begin
        errors++;
        $display("FAIL vec[%0d] addr=%h got=%h want=%h",
                 i, vt[i].ba, v, vt[i].exp);
      end
    end
    pulse_reset();

    // one-shot, P=5: PEND after edge 7
    wr(0, B + 32'h04, 32'd5);
    wr(0, B + 32'h00, 32'h9);
    step(6);
    chk("os_irq_early", 32'(irq[0]), 32'h0);
    step(1);
    chk("os_irq", 32'(irq[0]), 32'h1);
    chk("os_irq_any", 32'(irq_any), 32'h1);
    rdchk(0, B + 32'h08, 32'h0, "os_count");
    step(1);
    rdchk(0, B + 32'h00, 32'h18, "os_ctrl");
    step(3);
    chk("os_irq_hold", 32'(irq[0]), 32'h1);
    wr(0, B + 32'h00, 32'h8);
    chk("os_irq_clr", 32'(irq[0]), 32'h0);

    // PRESET=0 behaves like P=1
    wr(0, B + 32'h10, 32'h9);
    step(2);
    chk("p0_irq_early", 32'(irq[1]), 32'h0);
    step(1);
    chk("p0_irq", 32'(irq[1]), 32'h1);
    wr(0, B + 32'h10, 32'h0);

    // auto-reload, P=3
    wr(0, B + 32'h14, 32'd3);
    wr(0, B + 32'h10, 32'hB);
    step(2);
    for (int j = 0; j < 10; j++) begin
      rd(0, B + 32'h18, v);
      chk($sformatf("ar_count[%0d]", j), v, cseq[j]);
      chk($sformatf("ar_irq[%0d]", j), 32'(irq[1]), iseq[j]);
      step(1);
    end
    wr(0, B + 32'h14, 32'd3);
    chk("ar_pend_clr", 32'(irq[1]), 32'h0);
    step(1);
    chk("ar_pend_wait", 32'(irq[1]), 32'h0);
    step(1);
    chk("ar_pend_again", 32'(irq[1]), 32'h1);
    wr(0, B + 32'h10, 32'h0);

    // EN cleared mid-count, then re-enabled
    wr(0, B + 32'h04, 32'd100);
    wr(0, B + 32'h00, 32'h1);
    step(9);
    wr(0, B + 32'h00, 32'h0);
    step(3);
    rdchk(0, B + 32'h08, 32'd92, "frz_count");
    wr(0, B + 32'h00, 32'h1);
    rdchk(0, B + 32'h08, 32'd92, "reen_e0");
    step(1);
    rdchk(0, B + 32'h08, 32'd92, "reen_e1");
    step(1);
    rdchk(0, B + 32'h08, 32'd100, "reen_e2");
    wr(0, B + 32'h00, 32'h0);

    // free-run wrap on the 32-bit build
    wr(0, B + 32'h04, 32'd2);
    wr(0, B + 32'h00, 32'h5);
    step(2);
    rdchk(0, B + 32'h08, 32'd2, "fr_c2");
    step(1);
    rdchk(0, B + 32'h08, 32'd1, "fr_c1");
    step(1);
    rdchk(0, B + 32'h08, 32'd0, "fr_c0");
    step(1);
    rdchk(0, B + 32'h08, 32'hFFFFFFFF, "fr_wrap");
    rdchk(0, B + 32'h00, 32'h15, "fr_ctrl");
    chk("fr_irq_masked", 32'(irq[0]), 32'h0);
    wr(0, B + 32'h00, 32'h0);

    // free-run on 8-bit ch3: unmasking clears PEND, irq at next wrap
    wr(1, B + 32'h34, 32'd2);
    wr(1, B + 32'h30, 32'h5);
    step(5);
    rdchk(1, B + 32'h38, 32'hFF, "fr8_wrap");
    rdchk(1, B + 32'h30, 32'h15, "fr8_ctrl");
    chk("fr8_irq_masked", 32'(irq4[3]), 32'h0);
    wr(1, B + 32'h30, 32'hD);
    chk("fr8_irq_clr", 32'(irq4[3]), 32'h0);
    n = 0;
    while (irq4[3] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("fr8_wrap_gap", 32'(n), 32'd255);
    chk("fr8_irq_any", 32'(irq4_any), 32'h1);

    // reset in the middle of activity
    wr(0, B + 32'h04, 32'd1);
    wr(0, B + 32'h00, 32'h9);
    wr(0, B + 32'h14, 32'd50);
    wr(0, B + 32'h10, 32'hB);
    step(2);
    chk("pre_rst_irq", 32'(irq[0]), 32'h1);
    pulse_reset();
    chk("mrst_irq", 32'(irq), 32'h0);
    chk("mrst_irq_any", 32'(irq_any), 32'h0);
    chk("mrst_irq4", 32'(irq4), 32'h0);
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 4; r++)
        rdchk(0, B + 32'(c * 16 + r * 4), 32'h0,
              $sformatf("mrst_ch%0d_r%0d", c, r));
    step(5);
    rdchk(0, B + 32'h18, 32'h0, "mrst_idle_c1");
    rdchk(1, B + 32'h38, 32'h0, "mrst_idle_d4");

`ifdef TC_PRESCALE_EN
    // PRESCALE=3, P=2: COUNT steps every 4 cycles, PEND after edge 10
    wr(0, B + 32'h0C, 32'd3);
    wr(0, B + 32'h04, 32'd2);
    wr(0, B + 32'h00, 32'h9);
    step(9);
    chk("ps_irq_early", 32'(irq[0]), 32'h0);
    step(1);
    chk("ps_irq", 32'(irq[0]), 32'h1);
    rdchk(0, B + 32'h0C, 32'd3, "ps_reg");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
